// File: rtl/mealy_lane_scheduler_if.sv
// Lane handshake, control and match/counter read bundle for mealy_lane_scheduler.
// master = lane sources and counter reader, slave = the scheduler.
interface mealy_lane_scheduler_if #(
    parameter int NLANES = 4,
    parameter int CNT_W  = 8
);
    localparam int LW = $clog2(NLANES);

    logic              en;
    logic              clr;
    logic [NLANES-1:0] lane_valid;
    logic [NLANES-1:0] lane_bit;
    logic [NLANES-1:0] lane_ready;
    logic              match_valid;
    logic [LW-1:0]     match_lane;
    logic [LW-1:0]     cnt_sel;
    logic [CNT_W-1:0]  cnt_out;

    modport master (
        output en, clr, lane_valid, lane_bit, cnt_sel,
        input  lane_ready, match_valid, match_lane, cnt_out
    );

    modport slave (
        input  en, clr, lane_valid, lane_bit, cnt_sel,
        output lane_ready, match_valid, match_lane, cnt_out
    );
endinterface

// File: rtl/mealy_lane_scheduler.sv
// One shared overlapping "101" Mealy detector time-multiplexed over NLANES lanes by a
// round-robin arbiter. Define MEALY_SCHED_CNT_EN to build the per-lane match counters.
module mealy_lane_scheduler #(
    parameter int NLANES = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mealy_lane_scheduler_if.slave bus
);
    localparam int LW = $clog2(NLANES);

    typedef enum logic [1:0] {
        S0     = 2'b00,
        S1     = 2'b01,
        S2     = 2'b10,
        S_UNUS = 2'b11
    } state_e;

    state_e            ctx_q [NLANES];
    state_e            ctx_d [NLANES];
    logic [LW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              match_valid_q, match_valid_d;
    logic [LW-1:0]     match_lane_q, match_lane_d;

    logic              grant_found;
    logic [LW-1:0]     grant_idx;
    logic [LW-1:0]     scan_idx;
    logic              transfer;
    state_e            cur_state;
    logic              cur_bit;

    // Search upward from rr_ptr; LW-bit addition wraps because NLANES is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NLANES; i++) begin
            scan_idx = rr_ptr_q + LW'(i);
            if (!grant_found && bus.lane_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign transfer       = rst_n && bus.en && !bus.clr && grant_found;
    assign bus.lane_ready = transfer ? (NLANES'(1) << grant_idx) : '0;

    always_comb begin
        ctx_d         = ctx_q;
        rr_ptr_d      = rr_ptr_q;
        match_valid_d = 1'b0;
        match_lane_d  = match_lane_q;
        cur_state     = ctx_q[grant_idx];
        cur_bit       = bus.lane_bit[grant_idx];
        if (bus.clr) begin
            for (int i = 0; i < NLANES; i++) begin
                ctx_d[i] = S0;
            end
            rr_ptr_d = '0;
        end else if (transfer) begin
            case (cur_state)
                S1: ctx_d[grant_idx] = cur_bit ? S1 : S2;
                S2: begin
                    ctx_d[grant_idx] = cur_bit ? S1 : S0;
                    if (cur_bit) begin
                        match_valid_d = 1'b1;
                        match_lane_d  = grant_idx;
                    end
                end
                default: ctx_d[grant_idx] = cur_bit ? S1 : S0;
            endcase
            rr_ptr_d = grant_idx + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLANES; i++) begin
                ctx_q[i] <= S0;
            end
            rr_ptr_q      <= '0;
            match_valid_q <= 1'b0;
            match_lane_q  <= '0;
        end else begin
            ctx_q         <= ctx_d;
            rr_ptr_q      <= rr_ptr_d;
            match_valid_q <= match_valid_d;
            match_lane_q  <= match_lane_d;
        end
    end

    assign bus.match_valid = match_valid_q;
    assign bus.match_lane  = match_lane_q;

`ifdef MEALY_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt_q [NLANES];
    logic [CNT_W-1:0] cnt_d [NLANES];

    // Counters advance on the same edge that raises match_valid and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr) begin
            for (int i = 0; i < NLANES; i++) begin
                cnt_d[i] = '0;
            end
        end else if (match_valid_d && (cnt_q[match_lane_d] != '1)) begin
            cnt_d[match_lane_d] = cnt_q[match_lane_d] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt_out = cnt_q[bus.cnt_sel];
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^bus.cnt_sel;
    assign bus.cnt_out    = '0;
`endif
endmodule

// File: tb/tb_mealy_lane_scheduler.sv
// Directed bench for mealy_lane_scheduler with a stream-level reference model checked
// every cycle, plus hand-computed literal expectations for the test-plan scenarios.
module tb_mealy_lane_scheduler;
    localparam int NL    = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef MEALY_SCHED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    mealy_lane_scheduler_if #(.NLANES(NL), .CNT_W(CW)) bus ();

    mealy_lane_scheduler #(.NLANES(NL), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: last three accepted bits per lane; a match is the window reading 1,0,1.
    logic [2:0] win [NL];
    int         exp_cnt [NL];
    int         rr;
    logic       exp_mv;
    int         exp_ml;
    int         g;
    logic [NL-1:0] exp_ready;
    logic       nxt_mv;

    function automatic int expCnt(input int v);
        return CNT_EN ? v : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en_i, input logic clr_i, input logic [NL-1:0] valid_i,
                                 input logic [NL-1:0] bit_i, input logic [1:0] sel_i);
        @(posedge clk);
        #1;
        bus.en         = en_i;
        bus.clr        = clr_i;
        bus.lane_valid = valid_i;
        bus.lane_bit   = bit_i;
        bus.cnt_sel    = sel_i;
    endtask

    task automatic sampleNow();
        @(negedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NL; i++) begin
            win[i]     = 3'b000;
            exp_cnt[i] = 0;
        end
        rr     = 0;
        exp_mv = 1'b0;
        exp_ml = 0;
    endtask

    initial modelReset();

    // Compare against the model on every falling edge, then advance the model as the
    // following rising edge will with the inputs currently applied.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_ready", int'(bus.lane_ready), 0);
            checkOutput("rst_match_valid", int'(bus.match_valid), 0);
            checkOutput("rst_match_lane", int'(bus.match_lane), 0);
            checkOutput("rst_cnt_out", int'(bus.cnt_out), 0);
            modelReset();
        end else begin
            g = -1;
            if (bus.en && !bus.clr) begin
                for (int k = 0; k < NL; k++) begin
                    if (g < 0 && bus.lane_valid[(rr + k) % NL]) g = (rr + k) % NL;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;

            checkOutput("m_ready", int'(bus.lane_ready), int'(exp_ready));
            checkOutput("m_match_valid", int'(bus.match_valid), int'(exp_mv));
            if (exp_mv) checkOutput("m_match_lane", int'(bus.match_lane), exp_ml);
            checkOutput("m_cnt_out", int'(bus.cnt_out), expCnt(exp_cnt[bus.cnt_sel]));

            nxt_mv = 1'b0;
            if (bus.clr) begin
                for (int i = 0; i < NL; i++) begin
                    win[i]     = 3'b000;
                    exp_cnt[i] = 0;
                end
                rr = 0;
            end else if (g >= 0) begin
                win[g] = {win[g][1:0], bus.lane_bit[g]};
                if (win[g] == 3'b101) begin
                    nxt_mv = 1'b1;
                    exp_ml = g;
                    if (exp_cnt[g] < CMAX) exp_cnt[g]++;
                end
                rr = (g + 1) % NL;
            end
            exp_mv = nxt_mv;
        end
    end

    logic [NL-1:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        bus.en = 1'b0; bus.clr = 1'b0; bus.lane_valid = '0; bus.lane_bit = '0; bus.cnt_sel = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single lane: 1,0,1,0,1 on lane 0
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        sampleNow();
        checkOutput("single_first_match", int'(bus.match_valid), 1);
        checkOutput("single_first_lane", int'(bus.match_lane), 0);
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        sampleNow();
        checkOutput("single_gap", int'(bus.match_valid), 0);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd0);
        sampleNow();
        checkOutput("single_second_match", int'(bus.match_valid), 1);
        checkOutput("single_cnt", int'(bus.cnt_out), expCnt(2));

        // Fairness: all lanes requesting from rr_ptr = 0
        applyStimulus(1, 1, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 0, 4'b1111, 4'b0000, 2'd0);
            sampleNow();
            checkOutput($sformatf("fair_ready%0d", k), int'(bus.lane_ready), int'(fair_exp[k]));
        end

        // Interleaving: lane1 1,0,1 and lane2 1,1,0
        applyStimulus(1, 1, 4'b0000, 4'b0000, 2'd1);
        applyStimulus(1, 0, 4'b0010, 4'b0010, 2'd1);
        applyStimulus(1, 0, 4'b0100, 4'b0100, 2'd1);
        applyStimulus(1, 0, 4'b0010, 4'b0000, 2'd1);
        applyStimulus(1, 0, 4'b0100, 4'b0100, 2'd1);
        applyStimulus(1, 0, 4'b0010, 4'b0010, 2'd1);
        applyStimulus(1, 0, 4'b0100, 4'b0000, 2'd1);
        sampleNow();
        checkOutput("ilv_lane1_match", int'(bus.match_valid), 1);
        checkOutput("ilv_lane1_idx", int'(bus.match_lane), 1);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd1);
        sampleNow();
        checkOutput("ilv_lane2_nomatch", int'(bus.match_valid), 0);
        checkOutput("ilv_cnt1", int'(bus.cnt_out), expCnt(1));
        applyStimulus(1, 0, 4'b0100, 4'b0100, 2'd2);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd2);
        sampleNow();
        checkOutput("ilv_lane2_match", int'(bus.match_valid), 1);
        checkOutput("ilv_lane2_idx", int'(bus.match_lane), 2);

        // Saturation: 300 matches on lane 3
        applyStimulus(1, 1, 4'b0000, 4'b0000, 2'd3);
        applyStimulus(1, 0, 4'b1000, 4'b1000, 2'd3);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1, 0, 4'b1000, 4'b0000, 2'd3);
            applyStimulus(1, 0, 4'b1000, 4'b1000, 2'd3);
        end
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd3);
        sampleNow();
        checkOutput("sat_cnt3", int'(bus.cnt_out), expCnt(255));
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 0, 4'b1000, 4'b0000, 2'd3);
            applyStimulus(1, 0, 4'b1000, 4'b1000, 2'd3);
        end
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd3);
        sampleNow();
        checkOutput("sat_cnt3_hold", int'(bus.cnt_out), expCnt(255));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 4'b0000, 4'b0000, 2'(k));
            sampleNow();
            checkOutput($sformatf("sat_other%0d", k), int'(bus.cnt_out), 0);
        end

        // clr mid-pattern, then en=0 holding context
        applyStimulus(1, 1, 4'b0000, 4'b0000, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        applyStimulus(1, 1, 4'b0001, 4'b0001, 2'd0);
        sampleNow();
        checkOutput("clr_no_ready", int'(bus.lane_ready), 0);
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd0);
        sampleNow();
        checkOutput("clr_no_match", int'(bus.match_valid), 0);
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 4'b0001, 4'b0001, 2'd0);
            sampleNow();
            checkOutput("en0_ready", int'(bus.lane_ready), 0);
        end
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd0);
        sampleNow();
        checkOutput("en_hold_match", int'(bus.match_valid), 1);
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(0, 0, 4'b0001, 4'b0000, 2'd0);
        sampleNow();
        checkOutput("en0_pending_pulse", int'(bus.match_valid), 1);

        // Asynchronous reset in the middle of a match pulse
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_match_valid", int'(bus.match_valid), 0);
        checkOutput("arst_ready", int'(bus.lane_ready), 0);
        checkOutput("arst_cnt", int'(bus.cnt_out), 0);
        bus.lane_valid = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'd0);
        applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd0);
        sampleNow();
        checkOutput("arst_no_match", int'(bus.match_valid), 0);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd0);
        sampleNow();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/mealy_lane_scheduler.md
Name: mealy_lane_scheduler

Overview:
Time-multiplexes one shared overlapping "101" Mealy detector datapath across NLANES serial input lanes.
- Each lane offers one bit per transfer through a valid/ready handshake.
- A round-robin arbiter grants at most one lane per cycle.
- The granted lane's saved detector context is loaded, advanced and written back.
- Per-lane match events and match counters are produced for the top-level wrapper, which maps them onto ui_in/uo_out.

Parameters:
NLANES, 4, number of serial lanes; power of two, 2..8.
CNT_W, 8, width of each per-lane saturating match counter.
LW, $clog2(NLANES), lane index width; derived, not overridable.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; 0 = no grants issued
clr  input  1  synchronous clear of all contexts and counters
lane_valid  input  NLANES  per-lane bit available
lane_bit  input  NLANES  per-lane serial data bit
lane_ready  output  NLANES  one-hot grant; combinational
match_valid  output  1  registered pulse, one cycle per detected "101"
match_lane  output  LW  lane index of that match; valid with match_valid
cnt_sel  input  LW  selects the lane counter to read
cnt_out  output  CNT_W  match count of lane cnt_sel; combinational read

Behaviour:
- Reset (rst_n=0, asynchronous), all values 0:
  - every lane context = S0
  - rr_ptr = 0
  - match_valid = 0, match_lane = 0
  - all counters = 0, so cnt_out = 0
  - lane_ready = 0 while rst_n is low
- Context per lane is a 2-bit state: S0 idle (2'b00), S1 saw "1" (2'b01), S2 saw "10" (2'b10). The unused code 2'b11 behaves as S0.
- Transitions (bit b):
  - S0: b=1 -> S1, else stay S0
  - S1: b=1 -> stay S1, else -> S2
  - S2: b=1 -> S1 (match, overlap kept), else -> S0
- Match is Mealy: context == S2 and b == 1 at the moment of transfer.
- Arbitration:
  - When en=1 and clr=0, grant the first lane with lane_valid=1, searching upward from rr_ptr with wrap at NLANES-1 -> 0.
  - lane_ready is one-hot on the granted lane, or all zeros if there is no request, en=0, or clr=1.
  - lane_ready depends combinationally on lane_valid; lane_valid must not depend on lane_ready.
- Transfer = lane_valid[g] & lane_ready[g]. On a transfer:
  - ctx[g] <= next state
  - rr_ptr <= (g+1) mod NLANES
- No transfer: rr_ptr and all contexts hold.
- Ungranted lanes: context is untouched. They keep valid/bit stable until granted; a bit is consumed exactly once.
- Match output is registered with 1-cycle latency. In the cycle after a matching transfer on lane g: match_valid=1, match_lane=g. Otherwise match_valid=0 and match_lane holds its last value.
- Counter of lane g increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
- clr=1 (synchronous, wins over everything):
  - no grant in that cycle
  - all contexts -> S0, all counters -> 0
  - match_valid -> 0 next cycle
  - rr_ptr -> 0
- en=0: no grants. Contexts, counters and rr_ptr hold. A pending match_valid pulse from the previous cycle still appears.
- Reset mid-stream: partial patterns are lost; the first transfers after reset start from S0.
- Each lane behaves exactly like a standalone "101" detector fed only its accepted bits, regardless of interleaving.

Optional Feature:
MEALY_SCHED_CNT_EN
- Defined: per-lane CNT_W-bit saturating counters and the cnt_sel/cnt_out read path are implemented as described.
- Undefined: no counter storage; cnt_out is tied to 0 and cnt_sel is ignored. match_valid/match_lane are unchanged.

Test Plan:
- Single lane: lane 0 only valid, bits 1,0,1,0,1. Expected: match_valid pulses 1 cycle after the 3rd and 5th transfers, match_lane=0, and cnt_out(sel=0)=2.
- Fairness: all 4 lanes valid every cycle. Expected: lane_ready sequence 0001,0010,0100,1000,0001; no lane starves.
- Interleaving isolation: lane1 gets 1,0,1 and lane2 gets 1,1,0 interleaved. Expected: exactly one match on lane1, none on lane2; ctx2 ends in S2, and a later lane2 bit 1 gives a match with match_lane=2.
- Saturation: CNT_W=8, 300 matches on lane 3. Expected: cnt_out(sel=3)=255 and it stays there; other lanes read 0.
- clr and en: clr mid-pattern after lane0 bits 1,0, then bit 1. Expected: no match; with en=0, lane_ready=0 and contexts hold.
- Async reset: assert rst_n low between clock edges during activity. Expected: outputs go to 0 immediately; after release, sequence 0,1 on lane 0 gives no match.
